detect_timer: RTL and testbench

DETECT_TIMER -- requirements
Module: detect_timer

---
 rtl/detect_pkg.sv | 18 +
 rtl/detect_timer_run_qualifier.sv | 42 ++++
 rtl/detect_timer.sv | 185 ++++++++++++++++++
 tb/tb_detect_timer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_pkg.sv
// ---------------------------------------------------------------------------
// detect_pkg
// Shared definitions for the detect_timer block: the controller state
// encoding and the default parameter values used by the top level.
// ---------------------------------------------------------------------------
package detect_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT      = 24;
    localparam int DEB_N_DEFAULT      = 4;
    localparam int MIN_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/detect_timer_run_qualifier.sv
// ---------------------------------------------------------------------------
// run_qualifier
// Counts consecutive cycles on which 'cond' is high and pulses 'done' on the
// N-th such cycle.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   clear - holds the run count at zero and suppresses 'done'
//   cond  - the qualifying condition for this cycle
//   done  - combinational pulse on the cycle the N-th consecutive qualifying
//           sample is presented, so the owner can act on that same edge
// ---------------------------------------------------------------------------
module run_qualifier #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic cond,
    output logic done
);

    logic [3:0] count;

    // 'count' holds the number of qualifying samples already seen, so the
    // N-th one is the sample arriving while count == N-1.
    assign done = cond && !clear && (count == 4'(N - 1));

    // Any break in the run, an external clear, or a completed run starts the
    // count again from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (clear || !cond || done) begin
            count <= 4'd0;
        end else begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/detect_timer.sv
// ---------------------------------------------------------------------------
// detect_timer
// Measures the length of a "black" interval bounded by a debounced start run
// and a debounced finish run, and presents the length through a valid/ready
// handshake.
//
// Parameters:
//   DEB_N      - consecutive cycles needed to qualify a start or finish run
//   MIN_CYCLES - shortest interval that is reported; shorter ones are dropped
//   CNT_W      - width of the interval counter and of result_cycles
//
// Ports:
//   clk, rst       - clock and asynchronous active-high reset
//   start_detect   - upstream black-region flag
//   finish_detect  - upstream white-region flag
//   result_ready   - consumer accepts the current result
//   result_valid   - result_cycles / result_ovf are valid
//   result_cycles  - interval length in clk cycles (saturated on overflow)
//   result_ovf     - interval was longer than the counter can hold
//   busy           - controller is not idle
//   event_count    - number of accepted results, wraps at 256
// ---------------------------------------------------------------------------
module detect_timer
    import detect_pkg::*;
#(
    parameter int DEB_N      = DEB_N_DEFAULT,
    parameter int MIN_CYCLES = MIN_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_detect,
    input  logic             finish_detect,
    input  logic             result_ready,
    output logic             result_valid,
    output logic [CNT_W-1:0] result_cycles,
    output logic             result_ovf,
    output logic             busy,
    output logic [7:0]       event_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] DEB_LEN = CNT_W'(DEB_N);
    localparam logic [CNT_W:0]   MIN_LEN = (CNT_W + 1)'(MIN_CYCLES);

    state_t           state;
    state_t           next_state;
    logic             start_cond;
    logic             finish_cond;
    logic             start_done;
    logic             finish_done;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [CNT_W-1:0] snap;
    logic             snap_ovf;
    logic             fin_prev;
    logic [CNT_W-1:0] end_len;
    logic             end_ovf;
    logic             long_enough;

    // A cycle with both flags high or both low qualifies neither run.
    assign start_cond  = start_detect & ~finish_detect;
    assign finish_cond = finish_detect & ~start_detect;

    // The start qualifier only listens in IDLE and the finish qualifier only
    // in MEASURE, so activity elsewhere (notably in DONE) is ignored and each
    // run restarts from zero when its state is re-entered.
    run_qualifier #(.N(DEB_N)) u_start_qual (
        .clk   (clk),
        .rst   (rst),
        .clear (state != IDLE),
        .cond  (start_cond),
        .done  (start_done)
    );

    run_qualifier #(.N(DEB_N)) u_finish_qual (
        .clk   (clk),
        .rst   (rst),
        .clear (state != MEASURE),
        .cond  (finish_cond),
        .done  (finish_done)
    );

    // 'cnt' keeps running through the finish run, so the true interval is
    // the value captured on the first cycle of that run. When the run is a
    // single cycle long (or this is its first cycle) the live count is
    // already the answer.
    always_comb begin
        end_len = cnt;
        end_ovf = ovf;
        if (fin_prev) begin
            end_len = snap;
            end_ovf = snap_ovf;
        end
    end

    assign long_enough = ({1'b0, end_len} >= MIN_LEN);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Short intervals go straight back to IDLE without
    // producing a result; an overflowed interval is always reported.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_done) begin
                    next_state = MEASURE;
                end
            end
            MEASURE: begin
                if (finish_done) begin
                    next_state = (end_ovf || long_enough) ? DONE : IDLE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Interval counter, finish-run snapshot and registered outputs. The
    // counter is preloaded with DEB_N on entry to MEASURE because the whole
    // qualifying start run belongs to the interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            ovf           <= 1'b0;
            snap          <= '0;
            snap_ovf      <= 1'b0;
            fin_prev      <= 1'b0;
            result_valid  <= 1'b0;
            result_cycles <= '0;
            result_ovf    <= 1'b0;
            busy          <= 1'b0;
            event_count   <= 8'd0;
        end else begin
            busy <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    fin_prev <= 1'b0;
                    if (start_done) begin
                        cnt <= DEB_LEN;
                        ovf <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (cnt == CNT_MAX) begin
                        ovf <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    fin_prev <= finish_cond;
                    if (finish_cond && !fin_prev) begin
                        snap     <= cnt;
                        snap_ovf <= ovf;
                    end
                    if (next_state == DONE) begin
                        result_cycles <= end_len;
                        result_ovf    <= end_ovf;
                        result_valid  <= 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        event_count  <= event_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_detect_timer.sv
// ---------------------------------------------------------------------------
// tb_detect_timer
// Directed bench for detect_timer. Stimulus pushes the hand-computed result
// (length, overflow flag, cycle at which result_valid must first be seen)
// into a queue; a monitor pops and compares whenever result_valid rises and
// checks that the outputs hold while valid stays high. A second instance
// with CNT_W=8 covers counter saturation.
// ---------------------------------------------------------------------------
module tb_detect_timer;

    typedef struct {
        int cycles;
        bit ovf;
        int vcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_detect;
    logic        finish_detect;
    logic        result_ready;
    logic        result_valid;
    logic [23:0] result_cycles;
    logic        result_ovf;
    logic        busy;
    logic [7:0]  event_count;

    logic        s8_start;
    logic        s8_finish;
    logic        s8_ready;
    logic        s8_valid;
    logic [7:0]  s8_cycles;
    logic        s8_ovf;
    logic        s8_busy;
    logic [7:0]  s8_events;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t exp8_q[$];

    always #5 clk = ~clk;

    // Free-running edge counter used to check result latency.
    always @(posedge clk) cyc <= cyc + 1;

    detect_timer dut (
        .clk           (clk),
        .rst           (rst),
        .start_detect  (start_detect),
        .finish_detect (finish_detect),
        .result_ready  (result_ready),
        .result_valid  (result_valid),
        .result_cycles (result_cycles),
        .result_ovf    (result_ovf),
        .busy          (busy),
        .event_count   (event_count)
    );

    detect_timer #(.DEB_N(4), .MIN_CYCLES(16), .CNT_W(8)) dut8 (
        .clk           (clk),
        .rst           (rst),
        .start_detect  (s8_start),
        .finish_detect (s8_finish),
        .result_ready  (s8_ready),
        .result_valid  (s8_valid),
        .result_cycles (s8_cycles),
        .result_ovf    (s8_ovf),
        .busy          (s8_busy),
        .event_count   (s8_events)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one input pattern for n clock edges, returning 1 time unit after
    // the last edge. sel=1 drives the CNT_W=8 instance instead.
    task automatic applyStimulus(input bit st, input bit fi, input bit rd, input int n, input bit sel = 1'b0);
        start_detect  = sel ? 1'b0 : st;
        finish_detect = sel ? 1'b0 : fi;
        result_ready  = sel ? 1'b0 : rd;
        s8_start      = sel ? st : 1'b0;
        s8_finish     = sel ? fi : 1'b0;
        s8_ready      = sel ? rd : 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after the edge sampling the DEB_N-th finish cycle, so the
    // result must be visible at the very next monitor sample.
    task automatic pushExpected(input int cycles, input bit ovf, input bit sel = 1'b0);
        exp_t e;
        e.cycles = cycles;
        e.ovf    = ovf;
        e.vcyc   = cyc;
        if (sel) exp8_q.push_back(e);
        else     exp_q.push_back(e);
    endtask

    task automatic applyReset(input int prev_cycles);
        start_detect  = 1'b0;
        finish_detect = 1'b0;
        result_ready  = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_valid", 32'(result_valid), 0);
        checkOutput("rst_cycles", 32'(result_cycles), 0);
        checkOutput("rst_ovf", 32'(result_ovf), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_events", 32'(event_count), 0);
        if (prev_cycles != 0) checkOutput("rst_cleared_prev", 32'(result_cycles != 24'(prev_cycles)), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic monitorLoop();
        bit          prev = 1'b0;
        bit          prev8 = 1'b0;
        logic [31:0] held_c = 0;
        logic [31:0] held8_c = 0;
        logic        held_o = 1'b0;
        logic        held8_o = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                if (!prev) begin
                    checkOutput("result_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkOutput("result_cycles", 32'(result_cycles), e.cycles);
                        checkOutput("result_ovf", 32'(result_ovf), 32'(e.ovf));
                        checkOutput("valid_latency", cyc, e.vcyc);
                    end
                    held_c = 32'(result_cycles);
                    held_o = result_ovf;
                end else begin
                    checkOutput("stable_cycles", 32'(result_cycles), held_c);
                    checkOutput("stable_ovf", 32'(result_ovf), 32'(held_o));
                end
            end
            prev = (result_valid === 1'b1);

            if (s8_valid === 1'b1) begin
                if (!prev8) begin
                    checkOutput("result8_expected", 32'(exp8_q.size() != 0), 1);
                    if (exp8_q.size() != 0) begin
                        e = exp8_q.pop_front();
                        checkOutput("result8_cycles", 32'(s8_cycles), e.cycles);
                        checkOutput("result8_ovf", 32'(s8_ovf), 32'(e.ovf));
                        checkOutput("valid8_latency", cyc, e.vcyc);
                    end
                    held8_c = 32'(s8_cycles);
                    held8_o = s8_ovf;
                end else begin
                    checkOutput("stable8_cycles", 32'(s8_cycles), held8_c);
                    checkOutput("stable8_ovf", 32'(s8_ovf), 32'(held8_o));
                end
            end
            prev8 = (s8_valid === 1'b1);
        end
    endtask

    initial begin
        fork
            monitorLoop();
        join_none

        rst           = 1'b1;
        start_detect  = 1'b0;
        finish_detect = 1'b0;
        result_ready  = 1'b0;
        s8_start      = 1'b0;
        s8_finish     = 1'b0;
        s8_ready      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(result_valid), 0);
        checkOutput("reset_cycles", 32'(result_cycles), 0);
        checkOutput("reset_ovf", 32'(result_ovf), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_events", 32'(event_count), 0);
        checkOutput("reset8_valid", 32'(s8_valid), 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 2);

        // Basic 100-cycle interval.
        applyStimulus(1, 0, 0, 100);
        checkOutput("busy_measure", 32'(busy), 1);
        applyStimulus(0, 1, 0, 4);
        pushExpected(100, 0);
        applyStimulus(0, 0, 0, 3);
        applyStimulus(0, 0, 1, 1);
        checkOutput("events_1", 32'(event_count), 1);
        checkOutput("valid_after_ack", 32'(result_valid), 0);
        checkOutput("busy_after_ack", 32'(busy), 0);

        // A 3-cycle start run is too short to qualify.
        applyStimulus(1, 0, 0, 3);
        checkOutput("busy_short_run", 32'(busy), 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 100);
        applyStimulus(0, 1, 0, 4);
        pushExpected(100, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("events_2", 32'(event_count), 2);

        // Intervals of 10 and 15 are dropped; 16 is the shortest reported.
        applyStimulus(1, 0, 0, 10);
        applyStimulus(0, 1, 0, 4);
        checkOutput("busy_drop10", 32'(busy), 0);
        applyStimulus(1, 0, 0, 15);
        applyStimulus(0, 1, 0, 4);
        checkOutput("busy_drop15", 32'(busy), 0);
        checkOutput("events_after_drop", 32'(event_count), 2);
        applyStimulus(1, 0, 0, 16);
        applyStimulus(0, 1, 0, 4);
        pushExpected(16, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("events_3", 32'(event_count), 3);

        // Broken finish run and a both-low cycle still count: 20+2+1 = 23.
        applyStimulus(1, 0, 0, 20);
        applyStimulus(0, 1, 0, 2);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 0, 4);
        pushExpected(23, 0);
        // Activity during DONE with ready low must not disturb the result.
        applyStimulus(1, 0, 0, 6);
        applyStimulus(0, 1, 0, 5);
        applyStimulus(1, 1, 0, 2);
        applyStimulus(1, 0, 0, 7);
        checkOutput("valid_held", 32'(result_valid), 1);
        checkOutput("busy_done", 32'(busy), 1);
        checkOutput("events_held", 32'(event_count), 3);
        applyStimulus(1, 0, 1, 1);
        checkOutput("events_4", 32'(event_count), 4);
        // Start run restarts in IDLE: 3 samples are not enough, 30 total.
        applyStimulus(1, 0, 0, 3);
        checkOutput("busy_restart", 32'(busy), 0);
        applyStimulus(1, 0, 0, 27);
        applyStimulus(0, 1, 0, 4);
        pushExpected(30, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("events_5", 32'(event_count), 5);

        // Ready without valid does nothing.
        applyStimulus(0, 0, 1, 3);
        checkOutput("events_idle_ready", 32'(event_count), 5);
        checkOutput("valid_idle_ready", 32'(result_valid), 0);

        // Reset mid-MEASURE, then reset while a result is pending.
        applyStimulus(1, 0, 0, 20);
        applyReset(30);
        applyStimulus(1, 0, 0, 20);
        applyStimulus(0, 1, 0, 4);
        pushExpected(20, 0);
        applyStimulus(0, 0, 0, 2);
        applyReset(20);
        applyStimulus(1, 0, 0, 50);
        applyStimulus(0, 1, 0, 4);
        pushExpected(50, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("events_after_rst", 32'(event_count), 1);

        // 8-bit counter saturates on a 300-cycle interval.
        applyStimulus(1, 0, 0, 300, 1'b1);
        applyStimulus(0, 1, 0, 4, 1'b1);
        pushExpected(255, 1, 1'b1);
        applyStimulus(0, 0, 1, 1, 1'b1);
        checkOutput("events8", 32'(s8_events), 1);
        checkOutput("busy8_after_ack", 32'(s8_busy), 0);

        applyStimulus(0, 0, 0, 3);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("queue8_empty", exp8_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
